// File: rtl/host_sequencer_if.sv
// host_sequencer_if: start/status, load stream, core handshake, memory port and result stream of host_sequencer
interface host_sequencer_if #(parameter int AW = 8);
  logic start, busy, ld_valid, ld_ready, req, done, mem_we, rd_valid, rd_last, rd_ready, fin, err;
  logic [7:0] ld_data, mem_wdata, mem_rdata, rd_data;
  logic [AW-1:0] mem_addr;
  modport master (
    input  start, ld_valid, ld_data, done, mem_rdata, rd_ready,
    output busy, ld_ready, req, mem_addr, mem_wdata, mem_we, rd_valid, rd_data, rd_last, fin, err
  );
  modport slave (
    output start, ld_valid, ld_data, done, mem_rdata, rd_ready,
    input  busy, ld_ready, req, mem_addr, mem_wdata, mem_we, rd_valid, rd_data, rd_last, fin, err
  );
endinterface

// File: rtl/host_sequencer.sv
// host_sequencer: preloads data memory, runs one req/done handshake with timeout, drains results
module host_sequencer #(
  parameter int AW       = 8,
  parameter int N_IN     = 4,
  parameter int N_OUT    = 2,
  parameter int IN_BASE  = 0,
  parameter int OUT_BASE = 64,
  parameter int TW       = 12,
  parameter int TIMEOUT  = 4000
) (
  input logic clk,
  input logic reset,
  host_sequencer_if.master bus
);
  typedef enum logic [2:0] {IDLE, LOAD, REQ, RUN, DRAIN, FIN} state_t;
  localparam logic [AW-1:0] IN_LAST  = AW'(N_IN - 1);
  localparam logic [AW-1:0] OUT_LAST = AW'(N_OUT - 1);
  localparam logic [AW-1:0] IB       = AW'(IN_BASE);
  localparam logic [AW-1:0] OB       = AW'(OUT_BASE);
  localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 1);
  state_t state;
  logic [AW-1:0] idx;
  logic [TW-1:0] cnt;
  logic err, in_load, in_drain;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      idx   <= '0;
      cnt   <= '0;
      err   <= 1'b0;
    end else
      case (state)
        IDLE: if (bus.start) begin
          err   <= 1'b0;
          idx   <= '0;
          state <= (N_IN > 0) ? LOAD : REQ;
        end
        LOAD: if (bus.ld_valid) begin
          idx   <= (idx == IN_LAST) ? '0 : idx + 1'b1;
          state <= (idx == IN_LAST) ? REQ : LOAD;
        end
        REQ: begin
          cnt   <= '0;
          state <= RUN;
        end
        // done takes priority over a timeout landing in the same cycle
        RUN: if (bus.done) begin
          idx   <= '0;
          state <= (N_OUT > 0) ? DRAIN : FIN;
        end else if (cnt == CNT_LAST) begin
          err   <= 1'b1;
          state <= IDLE;
        end else
          cnt <= cnt + 1'b1;
        DRAIN: if (bus.rd_ready) begin
          idx   <= idx + 1'b1;
          state <= (idx == OUT_LAST) ? FIN : DRAIN;
        end
        FIN: state <= IDLE;
        default: state <= IDLE;
      endcase
  assign in_load       = state == LOAD;
  assign in_drain      = state == DRAIN;
  assign bus.busy      = state != IDLE;
  assign bus.ld_ready  = in_load;
  assign bus.req       = state == REQ;
  assign bus.fin       = state == FIN;
  assign bus.err       = err;
  assign bus.mem_addr  = in_load ? IB + idx : in_drain ? OB + idx : '0;
  assign bus.mem_we    = in_load & bus.ld_valid;
  assign bus.mem_wdata = in_load ? bus.ld_data : '0;
  assign bus.rd_valid  = in_drain;
  assign bus.rd_data   = in_drain ? bus.mem_rdata : '0;
  assign bus.rd_last   = in_drain & (idx == OUT_LAST);
endmodule

// File: tb/tb_host_sequencer.sv
// tb_host_sequencer: directed runs of two host_sequencer instances (IN_BASE 0 and 254) against a procedural model
module tb_host_sequencer;
  localparam int N_IN = 4, N_OUT = 2, TO = 20;
  logic clk = 0, reset = 0;
  logic start = 0, ld_valid = 0, done = 0, rd_ready = 0;
  logic [7:0] ld_data = 0;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  host_sequencer_if #(.AW(8)) a_if ();
  host_sequencer_if #(.AW(8)) b_if ();
  assign {a_if.start, a_if.ld_valid, a_if.ld_data, a_if.done, a_if.rd_ready} = {start, ld_valid, ld_data, done, rd_ready};
  assign {b_if.start, b_if.ld_valid, b_if.ld_data, b_if.done, b_if.rd_ready} = {start, ld_valid, ld_data, done, rd_ready};
  function automatic logic [7:0] rom(input logic [7:0] a);
    return a == 8'd64 ? 8'hA5 : a == 8'd65 ? 8'h5A : a ^ 8'h3C;
  endfunction
  assign a_if.mem_rdata = rom(a_if.mem_addr);
  assign b_if.mem_rdata = rom(b_if.mem_addr);
  host_sequencer #(.TIMEOUT(TO)) dut_a (.clk(clk), .reset(reset), .bus(a_if.master));
  host_sequencer #(.TIMEOUT(TO), .IN_BASE(254)) dut_b (.clk(clk), .reset(reset), .bus(b_if.master));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // monitors on the A instance (plus B write addresses)
  int req_cnt = 0, fin_cnt = 0, busy_cyc = 0;
  logic [7:0] wa_q[$], wd_q[$], wb_q[$], ra_q[$];
  logic [7:0] last_addr = 0;
  always @(posedge clk) begin
    req_cnt  <= req_cnt + 32'(a_if.req);
    fin_cnt  <= fin_cnt + 32'(a_if.fin);
    busy_cyc <= busy_cyc + 32'(a_if.busy);
    if (a_if.mem_we) begin
      wa_q.push_back(a_if.mem_addr);
      wd_q.push_back(a_if.mem_wdata);
    end
    if (b_if.mem_we) wb_q.push_back(b_if.mem_addr);
    if (a_if.rd_valid && rd_ready) begin
      ra_q.push_back(a_if.mem_addr);
      if (a_if.rd_last) last_addr <= a_if.mem_addr;
    end
  end

  // model: walks one run as a procedure, publishing expected outputs after every edge
  bit e_busy, e_ldr, e_req, e_rdv, e_last, e_fin, e_err;
  int e_idx = 0, e_mode = 0;
  task automatic zero();
    {e_busy, e_ldr, e_req, e_rdv, e_last, e_fin, e_err} = '0;
    e_idx = 0;
    e_mode = 0;
  endtask
  task automatic edge_ok(output bit ok);
    @(posedge clk or negedge reset);
    ok = reset;
    if (!ok) zero();
  endtask
  task automatic run_seq();
    bit ok;
    int n, k;
    e_err = 0; e_busy = 1;
    e_mode = 1; e_ldr = 1; e_idx = 0; n = 0;
    while (n < N_IN) begin
      edge_ok(ok); if (!ok) return;
      if (ld_valid) begin n++; e_idx = n; end
    end
    e_ldr = 0; e_mode = 0; e_req = 1;
    edge_ok(ok); if (!ok) return;
    e_req = 0;
    for (k = 0; k < TO; k++) begin
      edge_ok(ok); if (!ok) return;
      if (done) break;
    end
    if (k == TO) begin e_err = 1; e_busy = 0; return; end
    e_mode = 2; e_rdv = 1; n = 0; e_idx = 0; e_last = (N_OUT == 1);
    while (n < N_OUT) begin
      edge_ok(ok); if (!ok) return;
      if (rd_ready) begin n++; e_idx = n; e_last = (n == N_OUT - 1); end
    end
    e_rdv = 0; e_last = 0; e_mode = 0; e_fin = 1;
    edge_ok(ok); if (!ok) return;
    e_fin = 0; e_busy = 0;
  endtask
  initial begin : model
    bit ok;
    forever begin
      edge_ok(ok);
      if (ok && start) run_seq();
    end
  end

  always @(negedge clk) begin : cmp
    logic [7:0] ea, eb;
    ea = e_mode == 1 ? 8'(e_idx) : e_mode == 2 ? 8'(64 + e_idx) : 8'd0;
    eb = e_mode == 1 ? 8'(254 + e_idx) : ea;
    chk("cycle_a", {a_if.busy, a_if.ld_ready, a_if.req, a_if.mem_we, a_if.rd_valid, a_if.rd_last, a_if.fin, a_if.err,
                    a_if.mem_addr, a_if.mem_wdata, a_if.rd_data},
        {e_busy, e_ldr, e_req, e_ldr & ld_valid, e_rdv, e_last, e_fin, e_err, ea, e_ldr ? ld_data : 8'd0, e_rdv ? rom(ea) : 8'd0});
    chk("cycle_b", {b_if.busy, b_if.ld_ready, b_if.req, b_if.mem_we, b_if.rd_valid, b_if.rd_last, b_if.fin, b_if.err,
                    b_if.mem_addr, b_if.mem_wdata, b_if.rd_data},
        {e_busy, e_ldr, e_req, e_ldr & ld_valid, e_rdv, e_last, e_fin, e_err, eb, e_ldr ? ld_data : 8'd0, e_rdv ? rom(eb) : 8'd0});
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask
  task automatic go();
    start = 1; cyc(1); start = 0;
  endtask
  task automatic load(input logic [7:0] v0, v1, v2, v3, input bit tog);
    logic [7:0] v[4];
    v = '{v0, v1, v2, v3};
    for (int i = 0; i < 4; i++) begin
      ld_data = v[i]; ld_valid = 1; cyc(1);
      if (tog) begin ld_valid = 0; cyc(1); end
    end
    ld_valid = 0;
  endtask
  task automatic wait_req(input int r0);
    int g = 0;
    while (req_cnt == r0 && g < 50) begin cyc(1); g++; end
    chk("req_pulse_count", 32'(req_cnt - r0), 1);
  endtask
  task automatic wait_idle();
    int g = 0;
    while (a_if.busy && g < 100) begin cyc(1); g++; end
    chk("idle_reached", 32'(a_if.busy), 0);
  endtask
  task automatic pulse_done(input int k);
    cyc(k - 1); done = 1; cyc(1); done = 0;
  endtask

  initial begin : stim
    int w0, b0, a0, r0, f0, bc0;
    logic [7:0] wrap_exp[4], d_exp[4];
    wrap_exp = '{8'd254, 8'd255, 8'd0, 8'd1};
    cyc(2);
    chk("reset_state", {a_if.busy, a_if.ld_ready, a_if.req, a_if.mem_we, a_if.rd_valid, a_if.rd_last, a_if.fin, a_if.err,
                        a_if.mem_addr, a_if.mem_wdata, a_if.rd_data}, 0);
    reset = 1; cyc(1);
    // reset in the middle of LOAD, after two writes
    w0 = wa_q.size();
    go(); ld_valid = 1; ld_data = 8'h01; cyc(1); ld_data = 8'h02; cyc(1); ld_data = 8'h03;
    #1 reset = 0;
    #1 chk("reset_async_a", {a_if.busy, a_if.ld_ready, a_if.req, a_if.mem_we, a_if.rd_valid, a_if.rd_last, a_if.fin, a_if.err,
                             a_if.mem_addr, a_if.mem_wdata, a_if.rd_data}, 0);
    chk("reset_async_b", {b_if.busy, b_if.ld_ready, b_if.mem_we, b_if.mem_addr, b_if.mem_wdata}, 0);
    cyc(2); ld_valid = 0; reset = 1; cyc(2);
    chk("reset_write_count", 32'(wa_q.size() - w0), 2);
    chk("reset_release_idle", 32'(a_if.busy), 0);
    // clean run
    w0 = wa_q.size(); b0 = wb_q.size(); a0 = ra_q.size(); r0 = req_cnt; f0 = fin_cnt; bc0 = busy_cyc;
    rd_ready = 1;
    go(); load(8'h11, 8'h22, 8'h33, 8'h44, 0); wait_req(r0); pulse_done(10); wait_idle();
    d_exp = '{8'h11, 8'h22, 8'h33, 8'h44};
    chk("clean_write_count", 32'(wa_q.size() - w0), 4);
    for (int i = 0; i < 4; i++) begin
      chk("clean_write_addr", 32'(wa_q[w0 + i]), 32'(i));
      chk("clean_write_data", 32'(wd_q[w0 + i]), 32'(d_exp[i]));
      chk("wrap_write_addr", 32'(wb_q[b0 + i]), 32'(wrap_exp[i]));
    end
    chk("clean_read_count", 32'(ra_q.size() - a0), 2);
    chk("clean_read_addr0", 32'(ra_q[a0]), 64);
    chk("clean_read_addr1", 32'(ra_q[a0 + 1]), 65);
    chk("clean_rd_last_addr", 32'(last_addr), 65);
    chk("clean_fin_pulses", 32'(fin_cnt - f0), 1);
    chk("clean_busy_cycles", 32'(busy_cyc - bc0), 18);
    chk("clean_err", 32'(a_if.err), 0);
    // backpressure on both streams
    w0 = wa_q.size(); a0 = ra_q.size(); r0 = req_cnt;
    rd_ready = 0;
    go(); load(8'h55, 8'h66, 8'h77, 8'h88, 1); wait_req(r0); pulse_done(3);
    for (int i = 0; i < 3; i++) begin
      chk("stall_hold", 32'({a_if.rd_valid, a_if.mem_addr, a_if.rd_data}), 32'({1'b1, 8'd64, 8'hA5}));
      cyc(1);
    end
    rd_ready = 1; wait_idle();
    d_exp = '{8'h55, 8'h66, 8'h77, 8'h88};
    chk("bp_write_count", 32'(wa_q.size() - w0), 4);
    for (int i = 0; i < 4; i++) begin
      chk("bp_write_addr", 32'(wa_q[w0 + i]), 32'(i));
      chk("bp_write_data", 32'(wd_q[w0 + i]), 32'(d_exp[i]));
    end
    chk("bp_read_seq", 32'({ra_q[a0], ra_q[a0 + 1]}), 32'({8'd64, 8'd65}));
    // timeout: done never rises
    r0 = req_cnt; f0 = fin_cnt; bc0 = busy_cyc;
    go(); load(8'h01, 8'h02, 8'h03, 8'h04, 0); wait_req(r0); wait_idle();
    chk("timeout_err", 32'(a_if.err), 1);
    chk("timeout_no_fin", 32'(fin_cnt - f0), 0);
    chk("timeout_busy_cycles", 32'(busy_cyc - bc0), 25);
    // next start clears err; done on the last allowed RUN cycle wins
    r0 = req_cnt; f0 = fin_cnt;
    go();
    chk("err_cleared_on_start", 32'(a_if.err), 0);
    load(8'h09, 8'h08, 8'h07, 8'h06, 0); wait_req(r0); pulse_done(TO);
    chk("race_drain", 32'({a_if.rd_valid, a_if.err}), 32'(2'b10));
    wait_idle();
    chk("race_fin_pulses", 32'(fin_cnt - f0), 1);
    chk("race_err", 32'(a_if.err), 0);
    cyc(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end
endmodule
